// File: rtl/dense_pkg.sv
// Shared types for the dense-layer serializer.
//   DefaultDataW : default element / bias word width
//   elem_t       : signed element of DefaultDataW bits
//   ser_state_e  : serializer FSM state
package dense_pkg;

  localparam int unsigned DefaultDataW = 16;

  typedef logic signed [DefaultDataW-1:0] elem_t;

  typedef enum logic {
    StIdle   = 1'b0,
    StStream = 1'b1
  } ser_state_e;

endpackage

// File: rtl/dense_ser_bank.sv
// Capture register for one dense-layer output vector.
//   clk, rst_n : clock, async active-low reset (contents cleared to 0)
//   we         : capture wdata on the next rising edge
//   wdata      : NUM_ELEM packed elements, element i at [i*DATA_W +: DATA_W]
//   rd_idx     : element index for the combinational read port
//   rd_data    : element rd_idx (0 for an out-of-range index)
module dense_ser_bank #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_ELEM = 120,
  parameter int unsigned IDX_W    = $clog2(NUM_ELEM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [NUM_ELEM*DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [DATA_W-1:0]          rd_data
);

  logic [NUM_ELEM*DATA_W-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (we) begin
      mem_q <= wdata;
    end
  end

  // Explicit compare mux so a non-power-of-two NUM_ELEM never indexes past the vector.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_ELEM; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data = mem_q[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/dense_vec_serializer.sv
// Dense-layer vector serializer. Captures NUM_ELEM signed partial sums in one cycle and
// streams them one per beat (valid/ready) with frame_start/frame_end markers, driving an
// external 1-cycle-latency bias ROM so bias_out lines up with data_out on every beat.
//   clk, rst_n        : clock, async active-low reset (aborts any frame)
//   load, vec_in      : capture pulse and packed input vector
//   busy              : frame being streamed or last beat still pending
//   out_ready, valid  : downstream handshake
//   data_out, elem_idx, frame_start, frame_end : current beat
//   bias_rd_en, bias_addr, bias_q : bias ROM read port (addr = BIAS_BASE + index)
//   bias_out          : bias for the current beat (bias_q pass-through)
// Build option: define DENSE_SER_DBUF_EN to add a shadow bank so a load arriving during a
// frame is queued and streamed immediately after it with no bubble.
module dense_vec_serializer
  import dense_pkg::*;
#(
  parameter int unsigned DATA_W      = DefaultDataW,
  parameter int unsigned NUM_ELEM    = 120,
  parameter int unsigned IDX_W       = $clog2(NUM_ELEM),
  parameter int unsigned BIAS_ADDR_W = 8,
  parameter int unsigned BIAS_BASE   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [NUM_ELEM*DATA_W-1:0] vec_in,
  output logic                       busy,
  input  logic                       out_ready,
  output logic                       valid,
  output logic signed [DATA_W-1:0]   data_out,
  output logic [IDX_W-1:0]           elem_idx,
  output logic                       frame_start,
  output logic                       frame_end,
  output logic                       bias_rd_en,
  output logic [BIAS_ADDR_W-1:0]     bias_addr,
  input  logic [DATA_W-1:0]          bias_q,
  output logic signed [DATA_W-1:0]   bias_out
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_ELEM - 1);

  ser_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              prime_q, prime_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  elem_idx_q, elem_idx_d;
  logic              fs_q, fs_d;
  logic              fe_q, fe_d;

  logic              adv;
  logic              issue;
  logic              last;
  logic              start;
  logic              swap;
  logic [DATA_W-1:0] rd_data;

  // The output register may take a new beat when empty or when its beat is being accepted.
  assign adv   = !valid_q || out_ready;
  // prime_q idles the first cycle after a capture, giving two edges from load to first beat.
  assign issue = (state_q == StStream) && !prime_q && adv;
  assign last  = (idx_q == LastIdx);

`ifdef DENSE_SER_DBUF_EN
  // Two physical banks; act_q selects the one being streamed, the other is the shadow.
  logic              act_q, act_d;
  logic              shadow_full_q, shadow_full_d;
  logic              we_act, we_shadow;
  logic [DATA_W-1:0] rd_data0, rd_data1;

  // Once the last element has left the active bank it is free, so a load while the
  // final beat is still pending restarts straight into the active bank.
  assign start     = load && (state_q == StIdle);
  // Swap at the last issue if a frame is queued, or one arrives in that very cycle.
  assign swap      = issue && last && (shadow_full_q || load);
  // A load during a swap with a full shadow refills the bank being freed.
  assign we_act    = start || (swap && shadow_full_q && load);
  assign we_shadow = load && (state_q == StStream) && !shadow_full_q;

  dense_ser_bank #(
    .DATA_W  (DATA_W),
    .NUM_ELEM(NUM_ELEM),
    .IDX_W   (IDX_W)
  ) u_bank0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (act_q ? we_shadow : we_act),
    .wdata  (vec_in),
    .rd_idx (idx_q),
    .rd_data(rd_data0)
  );

  dense_ser_bank #(
    .DATA_W  (DATA_W),
    .NUM_ELEM(NUM_ELEM),
    .IDX_W   (IDX_W)
  ) u_bank1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (act_q ? we_act : we_shadow),
    .wdata  (vec_in),
    .rd_idx (idx_q),
    .rd_data(rd_data1)
  );

  assign rd_data = act_q ? rd_data1 : rd_data0;

  always_comb begin
    act_d         = act_q;
    shadow_full_d = shadow_full_q;
    if (swap) begin
      act_d         = !act_q;
      shadow_full_d = shadow_full_q && load;
    end else if (we_shadow) begin
      shadow_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q         <= 1'b0;
      shadow_full_q <= 1'b0;
    end else begin
      act_q         <= act_d;
      shadow_full_q <= shadow_full_d;
    end
  end
`else
  // Single bank: a load is taken only when fully idle.
  assign start = load && (state_q == StIdle) && !valid_q;
  assign swap  = 1'b0;

  dense_ser_bank #(
    .DATA_W  (DATA_W),
    .NUM_ELEM(NUM_ELEM),
    .IDX_W   (IDX_W)
  ) u_bank0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (start),
    .wdata  (vec_in),
    .rd_idx (idx_q),
    .rd_data(rd_data)
  );
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    prime_d    = 1'b0;
    valid_d    = valid_q;
    data_d     = data_q;
    elem_idx_d = elem_idx_q;
    fs_d       = fs_q;
    fe_d       = fe_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StStream;
          idx_d   = '0;
          prime_d = 1'b1;
        end
      end
      StStream: begin
        if (issue) begin
          if (last) begin
            if (swap) begin
              idx_d = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      valid_d    = 1'b1;
      data_d     = rd_data;
      elem_idx_d = idx_q;
      fs_d       = (idx_q == '0);
      fe_d       = last;
    end else if (out_ready) begin
      valid_d = 1'b0;
      fs_d    = 1'b0;
      fe_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      prime_q    <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      elem_idx_q <= '0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      prime_q    <= prime_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      elem_idx_q <= elem_idx_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
    end
  end

  // ROM read is issued on the same edge that loads data_out, so bias_q arrives with it and
  // holds through stalls because no read is issued while stalled.
  assign bias_rd_en  = issue;
  assign bias_addr   = issue ? (BIAS_ADDR_W'(BIAS_BASE) + BIAS_ADDR_W'(idx_q)) : '0;
  assign bias_out    = bias_q;

  assign valid       = valid_q;
  assign data_out    = data_q;
  assign elem_idx    = elem_idx_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign busy        = (state_q == StStream) || valid_q;

endmodule

// File: tb/tb_dense_vec_serializer.sv
// Scoreboard bench for dense_vec_serializer: a 120-element instance with a bias ROM model
// (ROM[a] = -a), plus a 10-element instance at BIAS_BASE=120 for address checks.
module tb_dense_vec_serializer;

  localparam int N1 = 120;
  localparam int N2 = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance 1
  logic              load, busy, out_ready, valid, frame_start, frame_end, bias_rd_en;
  logic [N1*16-1:0]  vec_in;
  logic [15:0]       data_out, bias_q, bias_out;
  logic [6:0]        elem_idx;
  logic [7:0]        bias_addr;

  // Instance 2
  logic              load2, busy2, valid2, fs2, fe2, rd_en2;
  logic [N2*16-1:0]  vec2;
  logic [15:0]       data2, bias_q2, bias_out2;
  logic [3:0]        idx2;
  logic [7:0]        addr2;

  dense_vec_serializer #(
    .DATA_W(16), .NUM_ELEM(N1), .BIAS_ADDR_W(8), .BIAS_BASE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .vec_in(vec_in), .busy(busy),
    .out_ready(out_ready), .valid(valid), .data_out(data_out), .elem_idx(elem_idx),
    .frame_start(frame_start), .frame_end(frame_end), .bias_rd_en(bias_rd_en),
    .bias_addr(bias_addr), .bias_q(bias_q), .bias_out(bias_out)
  );

  dense_vec_serializer #(
    .DATA_W(16), .NUM_ELEM(N2), .BIAS_ADDR_W(8), .BIAS_BASE(120)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .vec_in(vec2), .busy(busy2),
    .out_ready(1'b1), .valid(valid2), .data_out(data2), .elem_idx(idx2),
    .frame_start(fs2), .frame_end(fe2), .bias_rd_en(rd_en2),
    .bias_addr(addr2), .bias_q(bias_q2), .bias_out(bias_out2)
  );

  // Bias ROM models: 1-cycle latency, hold when not read, ROM[a] = -a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bias_q <= '0;
    else if (bias_rd_en) bias_q <= 16'(0 - int'(bias_addr));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bias_q2 <= '0;
    else if (rd_en2) bias_q2 <= 16'(0 - int'(addr2));
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] beat_word(logic [15:0] d, logic [15:0] b, logic [6:0] i,
                                            logic fs, logic fe);
    return {23'b0, d, b, i, fs, fe};
  endfunction

  function automatic logic [N1*16-1:0] mk_vec(int base);
    logic [N1*16-1:0] v;
    for (int i = 0; i < N1; i++) v[i*16 +: 16] = 16'(base + i);
    return v;
  endfunction

  logic [63:0] sb[$];

  task automatic push_frame(input int base);
    for (int i = 0; i < N1; i++)
      sb.push_back(beat_word(16'(base + i), 16'(0 - i), 7'(i), i == 0, i == N1 - 1));
  endtask

  // out_ready pattern: 0 = always ready, 1 = toggle, 2 = random stalls
  int rdy_mode = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pop on each accepted beat, check that stalled beats hold.
  logic [63:0] cur_w, held_w, exp_w;
  logic        held_vld = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_vld = 1'b0;
    end else begin
      cur_w = beat_word(data_out, bias_out, elem_idx, frame_start, frame_end);
      if (held_vld && valid) check_eq("stall_hold", cur_w, held_w);
      if (valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("extra_beat", 64'(sb.size()), 64'd1);
        end else begin
          exp_w = sb.pop_front();
          check_eq("beat", cur_w, exp_w);
        end
      end
      held_vld = valid && !out_ready;
      held_w   = cur_w;
    end
  end

  task automatic start_frame(input int base, input bit chk_lat);
    @(posedge clk); #1;
    vec_in = mk_vec(base);
    load   = 1'b1;
    push_frame(base);
    @(posedge clk); #1;
    load = 1'b0;
    if (chk_lat) begin
      check_eq("lat_t0_busy_valid", {busy, valid}, 2'b10);
      @(posedge clk); #1;
      check_eq("lat_t1_valid", valid, 1'b0);
      @(posedge clk); #1;
      check_eq("lat_t2_valid_fs", {valid, frame_start, data_out}, {1'b1, 1'b1, 16'd1});
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    check_eq("idle_after_frame", {busy, valid}, 2'b00);
  endtask

  task automatic wait_idx(input int n);
    bit found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      if (valid && elem_idx == 7'(n)) found = 1'b1;
    end
    check_eq("reach_idx", 64'(found), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb;
    bit seen;
    rst_n  = 1'b0;
    load   = 1'b0;
    vec_in = '0;
    load2  = 1'b0;
    vec2   = '0;
    #3;
    check_eq("reset_outs", {valid, data_out, elem_idx, frame_start, frame_end, busy,
                            bias_rd_en, bias_addr, bias_out}, 64'd0);
    check_eq("reset_outs2", {valid2, data2, idx2, fs2, fe2, busy2, rd_en2, addr2}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Always ready: 120 beats, exact latency
    start_frame(1, 1'b1);
    wait_drain(400);

    // Alternating and random back-pressure
    rdy_mode = 1;
    start_frame(300, 1'b0);
    wait_drain(800);
    rdy_mode = 2;
    start_frame(7000, 1'b0);
    wait_drain(1500);
    rdy_mode = 0;

    // Load in mid-frame
    start_frame(1, 1'b0);
    wait_idx(50);
    @(posedge clk); #1;
`ifdef DENSE_SER_DBUF_EN
    vec_in = mk_vec(1000);
    load   = 1'b1;
    push_frame(1000);
    @(posedge clk); #1;
    load = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (valid && frame_end && data_out == 16'd120) seen = 1'b1;
    end
    check_eq("dbuf_frame_end", 64'(seen), 64'd1);
    @(negedge clk);
    check_eq("dbuf_no_bubble", {valid, frame_start, data_out}, {1'b1, 1'b1, 16'd1000});
    wait_drain(600);
`else
    vec_in = mk_vec(500);
    load   = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check_eq("busy_load_ignored_busy", busy, 1'b1);
    wait_drain(400);
`endif

    // Asynchronous reset mid-frame
    start_frame(1, 1'b0);
    wait_idx(60);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_outs", {valid, data_out, elem_idx, frame_start, frame_end, busy,
                                  bias_rd_en, bias_addr, bias_out}, 64'd0);
    sb.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    start_frame(1, 1'b0);
    wait_drain(400);

    // Offset bias base, 10 elements
    @(posedge clk); #1;
    for (int i = 0; i < N2; i++) vec2[i*16 +: 16] = 16'(50 + i);
    load2 = 1'b1;
    @(posedge clk); #1;
    load2 = 1'b0;
    na = 0;
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rd_en2) begin
        check_eq("t6_addr", 64'(addr2), 64'(120 + na));
        na++;
      end
      if (valid2) begin
        check_eq("t6_beat", {idx2, data2, bias_out2, fs2, fe2},
                 {4'(nb), 16'(50 + nb), 16'(0 - (120 + nb)), nb == 0, nb == N2 - 1});
        nb++;
      end
    end
    check_eq("t6_reads", 64'(na), 64'd10);
    check_eq("t6_beats", 64'(nb), 64'd10);
    check_eq("t6_idle", busy2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
